y_writeback: RTL and testbench
==============================

Y_WRITEBACK -- requirements
Module: y_writeback

Interface
REQ-001 Parameter IDX_W, default 5, bit width of one Y-matrix row/column index.
REQ-002 Parameter DEPTH, default 4, number of result FIFO entries; power of two, at least 2.
REQ-003 Port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1; asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1, a one-cycle result-valid pulse; driven by the upstream update calculator's done flag.
REQ-006 Port in_data, input, 48, updated Y value as {real[47:24], imag[23:0]}.
REQ-007 Port in_row, input, IDX_W, row index of the updated element.
REQ-008 Port in_col, input, IDX_W, column index of the updated element.
REQ-009 Port in_ready, output, 1, FIFO not full.
REQ-010 Port mem_wr_en, output, 1, memory write request.
REQ-011 Port mem_addr, output, 2*IDX_W, memory write address as {row, col}.
REQ-012 Port mem_wr_data, output, 48, memory write data.
REQ-013 Port mem_ack, input, 1, memory accepted the current write this cycle.
REQ-014 Port busy, output, 1, high when the FIFO is non-empty or the state machine is not in IDLE.
REQ-015 Port overflow, output, 1, sticky flag: a result was dropped.
REQ-016 Port wr_count, output, 16, count of completed element updates.

Function
REQ-017 The block SHALL push {in_data, in_row, in_col} into the FIFO at a rising edge where in_valid=1 and the FIFO is not full.
REQ-018 The block SHALL drive in_ready = NOT full, where full is based on the registered occupancy.
REQ-019 When in_valid=1 while full, the block SHALL drop the entry and set overflow=1. This applies even if a pop occurs in the same cycle.
REQ-020 The block SHALL hold overflow at 1 until reset.
REQ-021 The FIFO SHALL wrap its read and write pointers modulo DEPTH.
REQ-022 A simultaneous push and pop while not full SHALL leave occupancy unchanged.
REQ-023 The FSM SHALL have three states: IDLE, WR_PRI and WR_SYM.
REQ-024 In IDLE with the FIFO non-empty, the FSM SHALL pop the head entry into holding registers (data, row, col) and go to WR_PRI.
REQ-025 In IDLE with the FIFO empty, the FSM SHALL remain in IDLE.
REQ-026 In WR_PRI the block SHALL drive mem_wr_en=1, mem_addr={row,col} and mem_wr_data=held data, holding them stable until mem_ack=1.
REQ-027 On mem_ack in WR_PRI, the FSM SHALL go to WR_SYM if row != col; otherwise it SHALL go to IDLE and increment wr_count.
REQ-028 In WR_SYM the block SHALL drive mem_wr_en=1, mem_addr={col,row} and the same data; this is the symmetric Y entry.
REQ-029 On mem_ack in WR_SYM, the FSM SHALL go to IDLE and increment wr_count.
REQ-030 The block SHALL ignore mem_ack in IDLE.
REQ-031 The block SHALL drive mem_wr_en, mem_addr and mem_wr_data directly from the state and holding registers (Moore). In IDLE, mem_wr_en=0 and mem_addr and mem_wr_data SHALL be 0.
REQ-032 Latency: for in_valid at edge T into an empty FIFO with the FSM in IDLE, mem_wr_en SHALL first be 1 in the cycle after edge T+1.
REQ-033 Minimum cost per element: one IDLE cycle plus one WR_PRI cycle, plus one WR_SYM cycle when off-diagonal.
REQ-034 wr_count SHALL wrap from 0xFFFF to 0x0000.
REQ-035 The block SHALL store data unmodified; it performs no arithmetic on in_data.

Reset
REQ-036 When reset=0, asynchronously: FSM to IDLE, FIFO pointers and occupancy to 0, holding registers to 0.
REQ-037 When reset=0, outputs SHALL be: mem_wr_en=0, mem_addr=0, mem_wr_data=0, overflow=0, wr_count=0, busy=0, in_ready=1.
REQ-038 A reset asserted mid-write SHALL abandon the write and discard all queued entries. No write SHALL resume after reset is released.

Verification
REQ-039 Off-diagonal element: push data 0x000100_FFFF00, row=2, col=5, mem_ack=1 always -> writes at addr {2,5} then {5,2}, both with that data; wr_count=1; busy=0 afterwards.
REQ-040 Diagonal element: push row=3, col=3 -> exactly one write at {3,3}; wr_count=1.
REQ-041 Backpressure: mem_ack held 0 for 10 cycles -> mem_wr_en, mem_addr and mem_wr_data stable throughout; write completes on the cycle mem_ack=1.
REQ-042 Overflow: mem_ack=0, push 5 entries with DEPTH=4 -> in_ready=0 after the 4th push (with no pop yet); 5th entry dropped; overflow=1. After mem_ack=1, exactly the first 4 entries are written in order.
REQ-043 Wrap: push and drain 9 off-diagonal entries in sequence -> 18 writes, correct order; wr_count=9.
REQ-044 Reset mid-operation: reset=0 during WR_SYM with 2 entries queued -> mem_wr_en=0 immediately; after release no writes occur; all counters 0.

Source files
------------

// File: rtl/y_writeback.sv
`default_nettype none
// y_writeback: buffers Y-matrix updates and writes each element plus its symmetric twin to memory.
// Revision 1.0
module y_writeback #(
  parameter int IDX_W = 5,
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [47:0]        in_data,
  input  logic [IDX_W-1:0]   in_row,
  input  logic [IDX_W-1:0]   in_col,
  output logic               in_ready,
  output logic               mem_wr_en,
  output logic [2*IDX_W-1:0] mem_addr,
  output logic [47:0]        mem_wr_data,
  input  logic               mem_ack,
  output logic               busy,
  output logic               overflow,
  output logic [15:0]        wr_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = 48 + 2*IDX_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WR_PRI = 2'd1;
  localparam logic [1:0] S_WR_SYM = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ENT_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [47:0]      hold_data_q;
  logic [IDX_W-1:0] hold_row_q, hold_col_q;
  logic             overflow_q;
  logic [15:0]      wr_count_q;

  logic             full, empty, push, pop, done;
  logic [ENT_W-1:0] head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;
  assign head  = fifo_q[rd_ptr_q];
  // An element completes on the ack of its last write: WR_PRI for diagonal, WR_SYM otherwise.
  assign done  = mem_ack && (((state_q == S_WR_PRI) && (hold_row_q == hold_col_q)) ||
                             (state_q == S_WR_SYM));

  assign in_ready = !full;
  assign busy     = !empty || (state_q != S_IDLE);
  assign overflow = overflow_q;
  assign wr_count = wr_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!empty) state_d = S_WR_PRI;
      S_WR_PRI: if (mem_ack) state_d = (hold_row_q != hold_col_q) ? S_WR_SYM : S_IDLE;
      S_WR_SYM: if (mem_ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state_q)
      S_WR_PRI: begin
        mem_wr_en   = 1'b1;
        mem_addr    = {hold_row_q, hold_col_q};
        mem_wr_data = hold_data_q;
      end
      S_WR_SYM: begin
        mem_wr_en   = 1'b1;
        mem_addr    = {hold_col_q, hold_row_q};
        mem_wr_data = hold_data_q;
      end
      default: ;
    endcase
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= {in_data, in_row, in_col};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_data_q <= '0;
      hold_row_q  <= '0;
      hold_col_q  <= '0;
      overflow_q  <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      if (pop) begin
        hold_data_q <= head[ENT_W-1 -: 48];
        hold_row_q  <= head[2*IDX_W-1 -: IDX_W];
        hold_col_q  <= head[IDX_W-1:0];
      end
      if (in_valid && full) overflow_q <= 1'b1;
      if (done) wr_count_q <= wr_count_q + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y_writeback.sv
`default_nettype none
// tb_y_writeback: directed self-checking bench for y_writeback.
// Revision 1.0
module tb_y_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [47:0] in_data;
  logic [4:0]  in_row, in_col;
  logic        in_ready;
  logic        mem_wr_en;
  logic [9:0]  mem_addr;
  logic [47:0] mem_wr_data;
  logic        mem_ack;
  logic        busy;
  logic        overflow;
  logic [15:0] wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [57:0] wlog[$];
  logic [57:0] wexp[$];

  y_writeback #(.IDX_W(5), .DEPTH(4)) dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_row(in_row), .in_col(in_col), .in_ready(in_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_ack(mem_ack), .busy(busy), .overflow(overflow), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && mem_wr_en && mem_ack) wlog.push_back({mem_addr, mem_wr_data});
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [4:0] c, input logic [47:0] d,
                      input bit wait_rdy);
    int n;
    if (wait_rdy) begin
      n = 0;
      while (!in_ready && n < 50) begin
        tick();
        n++;
      end
      if (!in_ready) chk("push ready timeout", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_row   = r;
    in_col   = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk("drain busy", 64'(busy), 64'd0);
  endtask

  task automatic exp_elem(input logic [4:0] r, input logic [4:0] c, input logic [47:0] d);
    wexp.push_back({r, c, d});
    if (r != c) wexp.push_back({c, r, d});
  endtask

  task automatic compare_log(input string tag);
    chk({tag, " write count"}, 64'(wlog.size()), 64'(wexp.size()));
    for (int i = 0; i < wexp.size() && i < wlog.size(); i++)
      chk($sformatf("%s write %0d", tag, i), 64'(wlog[i]), 64'(wexp[i]));
    wlog.delete();
    wexp.delete();
  endtask

  initial begin
    logic [47:0] d;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_row   = '0;
    in_col   = '0;
    mem_ack  = 1'b0;
    tick();
    tick();
    chk("rst mem_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst mem_addr", 64'(mem_addr), 64'd0);
    chk("rst mem_wr_data", 64'(mem_wr_data), 64'd0);
    chk("rst overflow", 64'(overflow), 64'd0);
    chk("rst wr_count", 64'(wr_count), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    reset = 1'b1;
    tick();

    // Off-diagonal element with latency check
    mem_ack = 1'b1;
    push(5'd2, 5'd5, 48'h000100_FFFF00, 1'b1);
    chk("lat idle cycle", 64'(mem_wr_en), 64'd0);
    tick();
    chk("lat first write en", 64'(mem_wr_en), 64'd1);
    chk("lat first addr", 64'(mem_addr), 64'h045);
    exp_elem(5'd2, 5'd5, 48'h000100_FFFF00);
    wait_idle();
    compare_log("offdiag");
    chk("offdiag wr_count", 64'(wr_count), 64'd1);

    // Diagonal element
    push(5'd3, 5'd3, 48'hABCDEF_123456, 1'b1);
    exp_elem(5'd3, 5'd3, 48'hABCDEF_123456);
    wait_idle();
    compare_log("diag");
    chk("diag wr_count", 64'(wr_count), 64'd2);

    // Backpressure: outputs must hold while mem_ack is low
    mem_ack = 1'b0;
    push(5'd1, 5'd4, 48'h123456_789ABC, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp en %0d", i), 64'(mem_wr_en), 64'd1);
      chk($sformatf("bp addr %0d", i), 64'(mem_addr), 64'h024);
      chk($sformatf("bp data %0d", i), 64'(mem_wr_data), 64'h123456_789ABC);
      tick();
    end
    chk("bp no early write", 64'(wlog.size()), 64'd0);
    mem_ack = 1'b1;
    tick();
    chk("bp pri done", 64'(wlog.size()), 64'd1);
    chk("bp sym addr", 64'(mem_addr), 64'h081);
    exp_elem(5'd1, 5'd4, 48'h123456_789ABC);
    wait_idle();
    compare_log("bp");
    chk("bp wr_count", 64'(wr_count), 64'd3);

    // Overflow: FSM stalled on a blocker, then five pushes into a 4-deep FIFO
    mem_ack = 1'b0;
    push(5'd0, 5'd0, 48'h0000AA_0000AA, 1'b1);
    exp_elem(5'd0, 5'd0, 48'h0000AA_0000AA);
    tick();
    for (int i = 1; i <= 4; i++) begin
      d = 48'h111111_000000 * 48'(i);
      push(5'(i), 5'(i + 1), d, 1'b0);
      exp_elem(5'(i), 5'(i + 1), d);
    end
    chk("ovf in_ready full", 64'(in_ready), 64'd0);
    chk("ovf not yet", 64'(overflow), 64'd0);
    push(5'd5, 5'd6, 48'hDEAD00_BEEF00, 1'b0);
    chk("ovf set", 64'(overflow), 64'd1);
    mem_ack = 1'b1;
    wait_idle();
    compare_log("ovf");
    chk("ovf sticky", 64'(overflow), 64'd1);
    chk("ovf wr_count", 64'(wr_count), 64'd8);

    // Reset during WR_SYM with two entries queued
    mem_ack = 1'b0;
    push(5'd1, 5'd2, 48'h00000A_00000A, 1'b1);
    tick();
    push(5'd2, 5'd3, 48'h00000B_00000B, 1'b1);
    push(5'd3, 5'd4, 48'h00000C_00000C, 1'b1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rmid in WR_SYM", 64'(mem_addr), 64'h041);
    wlog.delete();
    #2 reset = 1'b0;
    #1;
    chk("rmid mem_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rmid busy", 64'(busy), 64'd0);
    chk("rmid in_ready", 64'(in_ready), 64'd1);
    chk("rmid wr_count", 64'(wr_count), 64'd0);
    chk("rmid overflow", 64'(overflow), 64'd0);
    tick();
    reset   = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("rmid no writes", 64'(wlog.size()), 64'd0);
    chk("rmid busy after", 64'(busy), 64'd0);
    chk("rmid wr_count after", 64'(wr_count), 64'd0);

    // Pointer wrap: 9 off-diagonal elements streamed through
    for (int i = 0; i < 9; i++) begin
      d = 48'h010203_000000 + 48'(i * 17);
      push(5'(i), 5'(i + 10), d, 1'b1);
      exp_elem(5'(i), 5'(i + 10), d);
    end
    wait_idle();
    compare_log("wrap");
    chk("wrap wr_count", 64'(wr_count), 64'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
